bancoreg_ctrl: RTL and testbench
================================

Name: bancoreg_ctrl

Overview:
Write-port controller for the 8x16 register bank (bancoreg). After reset it clears all registers, because the bank has no reset of its own. It then shares the bank's single write port between two requesters with valid/ready handshakes and round-robin arbitration. Write commands are registered and presented to the bank's WriteReg, WriteData and RegWrite inputs one cycle after acceptance.

Parameters:
NREGS, 8, number of bank registers (power of two)
AW, 3, register address width (log2 NREGS)
DW, 16, data width
INIT_VALUE, 16'h0000, value written to every register during the clear sequence

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
clear_req  in  1  pulse; restarts the clear sequence
req0_valid  in  1  requester 0 has a write pending
req0_addr  in  AW  requester 0 target register
req0_data  in  DW  requester 0 write data
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid  in  1  requester 1 has a write pending
req1_addr  in  AW  requester 1 target register
req1_data  in  DW  requester 1 write data
req1_ready  out  1  requester 1 write accepted this cycle
rf_write_reg  out  AW  to bank WriteReg (registered)
rf_write_data  out  DW  to bank WriteData (registered)
rf_reg_write  out  1  to bank RegWrite (registered)
init_done  out  1  clear sequence complete; bank holds valid contents

Behaviour:
- Reset (asynchronous, takes effect immediately while reset_n=0):
  - state=ST_INIT, clear counter=0, round-robin pointer=requester 0.
  - rf_reg_write=0, rf_write_reg=0, rf_write_data=0, init_done=0.
  - req0_ready=0 and req1_ready=0 (combinational from state).
- ST_INIT:
  - On every clock edge, register rf_reg_write=1, rf_write_reg=counter, rf_write_data=INIT_VALUE, then increment the counter.
  - On the edge that issues address NREGS-1, go to ST_RUN and set init_done=1. The counter does not wrap into a ninth write.
  - Net result: exactly NREGS consecutive write cycles, addresses 0..NREGS-1 in order.
  - Both readys are 0 in this state; clear_req is ignored.
- ST_RUN, grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - reqN_ready = state==ST_RUN && !clear_req && grantN. At most one ready is high per cycle.
- ST_RUN, transfer when valid && ready at an edge:
  - Next cycle: rf_reg_write=1, rf_write_reg=addr, rf_write_data=data. Latency is 1 cycle; throughput is 1 write per cycle.
  - The pointer moves to the other requester after any grant.
- ST_RUN, no transfer: rf_reg_write=0; rf_write_reg and rf_write_data hold their previous values.
- clear_req=1 in ST_RUN:
  - No grant that cycle.
  - Next edge: state=ST_INIT, counter=0, init_done=0, rf_reg_write=0.
  - Pointer is unchanged. A pending request stays pending and is served after the new clear completes.
- Requester rule: valid, addr and data must stay stable until ready. The controller never drops an accepted write.
- Both requesters targeting the same address: writes are serialised in grant order, and the later write wins in the bank.
- Reset mid-operation (mid-clear or mid-run): all state is discarded. The clear restarts from address 0 after reset_n rises.

Decomposition:
- Package bancoreg_pkg holds:
  - the AW, DW and NREGS constants;
  - the state typedef {ST_INIT, ST_RUN};
  - the INIT_VALUE default.
- One sub-module, rr_arbiter2: a two-way round-robin grant with registered pointer. Inputs: clock, reset_n, req[1:0], advance. Output: gnt[1:0] (one-hot or zero).
- The state machine, clear counter and output registers stay in bancoreg_ctrl.

Test Plan:
1. Release reset_n with no requests -> rf_reg_write=1 for 8 consecutive cycles with rf_write_reg 0..7 and rf_write_data=0. init_done rises with the last write. Both readys stay 0 until ST_RUN.
2. In ST_RUN, req0_valid=1, addr=3, data=16'h1234 -> req0_ready=1 the same cycle. The next cycle shows rf_reg_write=1, rf_write_reg=3, rf_write_data=16'h1234. The following cycle shows rf_reg_write=0.
3. Both requesters held valid (req0: addr 1, 16'hAAAA; req1: addr 2, 16'h5555), pointer at req0 -> grants alternate req0, req1, req0, req1. Bank writes alternate 1/AAAA and 2/5555 each cycle, and no cycle is idle.
4. Both requesters target addr 5 (req0 16'h1111, req1 16'h2222), pointer at req1 -> write 5/2222 then 5/1111. A readback of register 5 shows 16'h1111.
5. clear_req pulsed while req1_valid=1 -> req1_ready=0 that cycle. Then 8 clear writes (addresses 0..7) with init_done=0. After init_done rises, req1 is granted and written.
6. Drop reset_n during the clear, right after address 4 is issued -> outputs go to 0 immediately, without waiting for a clock edge. After release, the clear restarts at address 0 and completes all 8 writes.

Source files
------------

// File: rtl/bancoreg_pkg.sv
// bancoreg_pkg: shared constants and state type for the register-bank write controller
package bancoreg_pkg;
   localparam int NREGS = 8;
   localparam int AW = 3;
   localparam int DW = 16;
   localparam logic [DW-1:0] INIT_VALUE = 16'h0000;
   typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer favours the requester not served last
module rr_arbiter2 (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic ptr;
   always_comb begin
      gnt[0] = req[0] && (!req[1] || !ptr);
      gnt[1] = req[1] && (!req[0] || ptr);
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) ptr <= 1'b0;
      else if (advance && |gnt) ptr <= gnt[0];
endmodule

// File: rtl/bancoreg_ctrl.sv
// bancoreg_ctrl: clears the 8x16 bank after reset, then shares its write port between two requesters
module bancoreg_ctrl #(
   parameter int NREGS = bancoreg_pkg::NREGS,
   parameter int AW = bancoreg_pkg::AW,
   parameter int DW = bancoreg_pkg::DW,
   parameter logic [DW-1:0] INIT_VALUE = bancoreg_pkg::INIT_VALUE
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear_req,
   input  logic          req0_valid,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic [AW-1:0] rf_write_reg,
   output logic [DW-1:0] rf_write_data,
   output logic          rf_reg_write,
   output logic          init_done
);
   import bancoreg_pkg::*;
   state_t state, state_next;
   logic [AW-1:0] cnt;
   logic [1:0] req, gnt;
   assign req = {req1_valid, req0_valid} & {2{state == ST_RUN && !clear_req}};
   rr_arbiter2 u_arb (
      .clock(clock),
      .reset_n(reset_n),
      .req(req),
      .advance(|gnt),
      .gnt(gnt)
   );
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= ST_INIT;
      else state <= state_next;
   always_comb
      state_next = state == ST_INIT ? (cnt == AW'(NREGS - 1) ? ST_RUN : ST_INIT)
                                    : (clear_req ? ST_INIT : ST_RUN);
   always_comb begin
      req0_ready = gnt[0];
      req1_ready = gnt[1];
   end
   // the counter rests at 0 in ST_RUN so a clear always starts from address 0
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         cnt <= '0;
         rf_reg_write <= 1'b0;
         rf_write_reg <= '0;
         rf_write_data <= '0;
         init_done <= 1'b0;
      end else begin
         init_done <= state_next == ST_RUN;
         rf_reg_write <= state == ST_INIT || |gnt;
         cnt <= state == ST_INIT ? cnt + 1'b1 : '0;
         if (state == ST_INIT) begin
            rf_write_reg <= cnt;
            rf_write_data <= INIT_VALUE;
         end else if (|gnt) begin
            rf_write_reg <= gnt[1] ? req1_addr : req0_addr;
            rf_write_data <= gnt[1] ? req1_data : req0_data;
         end
      end
endmodule

// File: tb/tb_bancoreg_ctrl.sv
// tb_bancoreg_ctrl: scoreboard bench with a transaction-level model of the clear sequence and round-robin sharing
module tb_bancoreg_ctrl;
   import bancoreg_pkg::*;
   typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; int at;} wr_t;
   logic clock, reset_n, clear_req;
   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr, rf_write_reg;
   logic [DW-1:0] req0_data, req1_data, rf_write_data;
   logic rf_reg_write, init_done;
   int checks = 0, errors = 0, n_cyc = 0;
   wr_t q[$];
   logic [DW-1:0] bank[NREGS], m_bank[NREGS];
   bit m_run;
   int m_idx, m_last;
   logic [1:0] g;
   bancoreg_ctrl dut (
      .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write),
      .init_done(init_done)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) n_cyc <= n_cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask
   // one clock cycle: drive inputs, predict grants from the model, queue the write the bank should see
   task automatic cyc1(input logic c, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic [1:0] gr);
      @(negedge clock);
      #1;
      clear_req = c; req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      #2;
      gr = 2'b00;
      if (m_run && !c) begin
         if (v0 && v1) gr = m_last == 0 ? 2'b10 : 2'b01;
         else gr = {v1, v0};
      end
      chk("req0_ready", req0_ready, gr[0]);
      chk("req1_ready", req1_ready, gr[1]);
      chk("init_done", init_done, m_run);
      if (!m_run) begin
         q.push_back('{m_idx[AW-1:0], INIT_VALUE, n_cyc + 1});
         m_bank[m_idx] = INIT_VALUE;
         m_idx++;
         if (m_idx == NREGS) m_run = 1;
      end else if (c) begin
         m_run = 0;
         m_idx = 0;
      end else if (gr[1]) begin
         q.push_back('{a1, d1, n_cyc + 1});
         m_bank[a1] = d1;
         m_last = 1;
      end else if (gr[0]) begin
         q.push_back('{a0, d0, n_cyc + 1});
         m_bank[a0] = d0;
         m_last = 0;
      end
   endtask
   initial begin : monitor
      wr_t e;
      logic [AW-1:0] last_a;
      logic [DW-1:0] last_d;
      last_a = '0;
      last_d = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            last_a = '0;
            last_d = '0;
         end else if (rf_reg_write) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got %0h/%0h expected no write", rf_write_reg, rf_write_data);
            end else begin
               e = q.pop_front();
               chk("wr_addr", rf_write_reg, e.a);
               chk("wr_data", rf_write_data, e.d);
               chk("wr_cycle", n_cyc, e.at);
            end
            bank[rf_write_reg] = rf_write_data;
            last_a = rf_write_reg;
            last_d = rf_write_data;
         end else begin
            chk("hold_addr", rf_write_reg, last_a);
            chk("hold_data", rf_write_data, last_d);
            if (q.size() > 0 && q[0].at <= n_cyc) begin
               checks++; errors++;
               $display("FAIL missing_write: got none expected %0h/%0h", q[0].a, q[0].d);
               void'(q.pop_front());
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic p0v, p1v;
      logic [AW-1:0] p0a, p1a;
      logic [DW-1:0] p0d, p1d;
      reset_n = 0; clear_req = 0;
      req0_valid = 0; req0_addr = '0; req0_data = '0;
      req1_valid = 0; req1_addr = '0; req1_data = '0;
      m_run = 0; m_idx = 0; m_last = 1;
      for (int i = 0; i < NREGS; i++) begin bank[i] = 'x; m_bank[i] = 'x; end
      repeat (3) @(negedge clock);
      #1;
      chk("rst_reg_write", rf_reg_write, 0);
      chk("rst_write_reg", rf_write_reg, 0);
      chk("rst_write_data", rf_write_data, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      @(posedge clock);
      #1 reset_n = 1;
      repeat (8) cyc1(0, 0, 0, 0, 0, 0, 0, g);
      cyc1(0, 1, 3, 16'h1234, 0, 0, 0, g);
      repeat (2) cyc1(0, 0, 0, 0, 0, 0, 0, g);
      cyc1(0, 0, 0, 0, 1, 0, 16'h0BEE, g);
      repeat (4) cyc1(0, 1, 1, 16'hAAAA, 1, 2, 16'h5555, g);
      cyc1(0, 1, 7, 16'h7777, 0, 0, 0, g);
      cyc1(0, 1, 5, 16'h1111, 1, 5, 16'h2222, g);
      cyc1(0, 1, 5, 16'h1111, 0, 0, 0, g);
      repeat (2) cyc1(0, 0, 0, 0, 0, 0, 0, g);
      chk("readback_r5", bank[5], 16'h1111);
      cyc1(1, 0, 0, 0, 1, 6, 16'h6666, g);
      repeat (8) cyc1(0, 0, 0, 0, 1, 6, 16'h6666, g);
      cyc1(0, 0, 0, 0, 1, 6, 16'h6666, g);
      chk("post_clear_grant1", g, 2'b10);
      cyc1(0, 0, 0, 0, 0, 0, 0, g);
      cyc1(1, 0, 0, 0, 0, 0, 0, g);
      repeat (5) cyc1(0, 0, 0, 0, 0, 0, 0, g);
      @(negedge clock);
      #1 reset_n = 0;
      #1;
      chk("async_reg_write", rf_reg_write, 0);
      chk("async_write_reg", rf_write_reg, 0);
      chk("async_write_data", rf_write_data, 0);
      chk("async_init_done", init_done, 0);
      chk("async_ready1", req1_ready, 0);
      chk("queue_at_reset", q.size(), 0);
      m_run = 0; m_idx = 0; m_last = 1;
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
      repeat (8) cyc1(0, 0, 0, 0, 0, 0, 0, g);
      p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p0v && $urandom_range(0, 1) == 1) begin
            p0v = 1; p0a = AW'($urandom_range(0, NREGS - 1)); p0d = DW'($urandom);
         end
         if (!p1v && $urandom_range(0, 2) != 0) begin
            p1v = 1; p1a = AW'($urandom_range(0, NREGS - 1)); p1d = DW'($urandom);
         end
         cyc1($urandom_range(0, 39) == 0, p0v, p0a, p0d, p1v, p1a, p1d, g);
         if (g[0]) p0v = 0;
         if (g[1]) p1v = 0;
      end
      repeat (10) cyc1(0, 0, 0, 0, 0, 0, 0, g);
      @(negedge clock);
      #1;
      chk("queue_drained", q.size(), 0);
      for (int i = 0; i < NREGS; i++) chk("bank_final", bank[i], m_bank[i]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
